// File: rtl/sram_pkg.sv
// Shared constants for the accelerator memories: address space, word widths, unreachable marker.
package sram_pkg;
  localparam int SRAM_ADDR_W = 13;
  localparam int SRAM_DEPTH  = 8192;

  localparam int OUT_DATA_W  = 16;
  localparam int WORK_DATA_W = 128;
  localparam int IN_DATA_W   = 8;

  localparam logic [OUT_DATA_W-1:0] DIST_INF = 16'hFFFF;
endpackage

// File: rtl/sram_read_port.sv
// Combinational read port: range-checks the address and muxes one word out of the array.
// Out-of-range addresses return all-zeros; shared by the 1R, 2R and ROM memory variants.
module sram_read_port
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = OUT_DATA_W,
  parameter int DEPTH      = SRAM_DEPTH
) (
  input  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1],
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    if (int'(addr) < DEPTH) begin
      data = mem[addr];
    end
  end

endmodule

// File: rtl/sram_1r1w.sv
// Behavioural single-clock SRAM, combinational read / synchronous write, array named Register.
// Define SRAM_1R1W_READ2_EN to add the second read port (ReadAddress2/ReadBus2) for the 2R1W variant.
module sram_1r1w
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = OUT_DATA_W,
  parameter int DEPTH      = SRAM_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteBus,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic [DATA_WIDTH-1:0] ReadBus
`ifdef SRAM_1R1W_READ2_EN
  ,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [DATA_WIDTH-1:0] ReadBus2
`endif
);

  logic [DATA_WIDTH-1:0] Register [0:DEPTH-1];

  // Reset only gates the write; contents are deliberately kept so preloaded data survives.
  always_ff @(posedge clock or posedge reset) begin
    if (!reset && WE && (int'(WriteAddress) < DEPTH)) begin
      Register[WriteAddress] <= WriteBus;
    end
  end

  sram_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rd1 (
    .mem  (Register),
    .addr (ReadAddress),
    .data (ReadBus)
  );

`ifdef SRAM_1R1W_READ2_EN
  sram_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rd2 (
    .mem  (Register),
    .addr (ReadAddress2),
    .data (ReadBus2)
  );
`endif

endmodule

// File: tb/tb_sram_1r1w.sv
// Directed and random checks of sram_1r1w against an associative-array memory model.
module tb_sram_1r1w;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clock;
  logic          reset;
  logic          WE;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteBus;
  logic [AW-1:0] ReadAddress;
  logic [DW-1:0] ReadBus;
`ifdef SRAM_1R1W_READ2_EN
  logic [AW-1:0] ReadAddress2;
  logic [DW-1:0] ReadBus2;
`endif

  logic [DW-1:0] model [int];
  int n_checks = 0;
  int n_fails  = 0;

  sram_1r1w dut (
    .clock        (clock),
    .reset        (reset),
    .WE           (WE),
    .WriteAddress (WriteAddress),
    .WriteBus     (WriteBus),
    .ReadAddress  (ReadAddress),
    .ReadBus      (ReadBus)
`ifdef SRAM_1R1W_READ2_EN
    ,
    .ReadAddress2 (ReadAddress2),
    .ReadBus2     (ReadBus2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write cycle through the port; the model only updates when the write should land.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    WE = 1'b1; WriteAddress = a; WriteBus = d;
    @(posedge clock);
    #1;
    WE = 1'b0;
    if (!reset) model[int'(a)] = d;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a);
    ReadAddress = a;
    #1;
    chk(tag, ReadBus, model[int'(a)]);
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; WriteAddress = '0; WriteBus = '0; ReadAddress = '0;
`ifdef SRAM_1R1W_READ2_EN
    ReadAddress2 = '0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Load and zero-latency read with no intervening clock edge
    wr(13'd5, 16'h0012);
    wr(13'd7, 16'h5555);
    @(negedge clock);
    #2;
    rd_chk("load_read5", 13'd5);

    // Read-during-write: old word before the edge, new word after
    @(negedge clock);
    WE = 1'b1; WriteAddress = 13'd7; WriteBus = 16'h00AB; ReadAddress = 13'd7;
    #1;
    chk("rdw_before_edge", ReadBus, 16'h5555);
    @(posedge clock);
    #1;
    WE = 1'b0;
    model[7] = 16'h00AB;
    chk("rdw_after_edge", ReadBus, 16'h00AB);

    // Writes held off for three edges while reset is high; contents survive reset
    @(negedge clock);
    reset = 1'b1; WE = 1'b1; WriteAddress = 13'd7; WriteBus = 16'h1234;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_blocks_write", ReadBus, 16'h00AB);
    ReadAddress = 13'd5;
    #1;
    chk("reset_keeps_array", ReadBus, 16'h0012);
    @(negedge clock);
    WE = 1'b0; reset = 1'b0;

    // Top and bottom of the address space on back-to-back cycles
    @(negedge clock);
    WE = 1'b1; WriteAddress = 13'd8191; WriteBus = 16'hFFFF;
    @(negedge clock);
    WriteAddress = 13'd0; WriteBus = 16'h0001;
    @(negedge clock);
    WE = 1'b0;
    model[8191] = 16'hFFFF;
    model[0]    = 16'h0001;
    rd_chk("edge_addr_8191", 13'd8191);
    rd_chk("edge_addr_0", 13'd0);

`ifdef SRAM_1R1W_READ2_EN
    ReadAddress = 13'd0; ReadAddress2 = 13'd8191;
    #1;
    chk("dual_port1", ReadBus, 16'h0001);
    chk("dual_port2", ReadBus2, 16'hFFFF);
    ReadAddress2 = 13'd0;
    #1;
    chk("dual_same_addr", ReadBus2, 16'h0001);
`endif

    // Reset raised mid-cycle with a write pending: nothing lands, then writes resume
    wr(13'd9, 16'h1111);
    @(negedge clock);
    WE = 1'b1; WriteAddress = 13'd9; WriteBus = 16'hBEEF; ReadAddress = 13'd9;
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midcycle_reset_no_write", ReadBus, 16'h1111);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    WE = 1'b0;
    model[9] = 16'hBEEF;
    chk("write_after_release", ReadBus, 16'hBEEF);

    // Random traffic over a small window so every read hits a known word
    for (int a = 16; a < 80; a++) wr(a[AW-1:0], DW'($urandom));
    for (int i = 0; i < 300; i++) begin
      logic          we_r;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      we_r = 1'($urandom_range(0, 1));
      wa   = AW'($urandom_range(16, 79));
      wd   = DW'($urandom);
      @(negedge clock);
      WE = we_r; WriteAddress = wa; WriteBus = wd;
      ReadAddress = AW'($urandom_range(16, 79));
`ifdef SRAM_1R1W_READ2_EN
      ReadAddress2 = AW'($urandom_range(16, 79));
`endif
      #1;
      chk("rand_read_pre", ReadBus, model[int'(ReadAddress)]);
`ifdef SRAM_1R1W_READ2_EN
      chk("rand_read2_pre", ReadBus2, model[int'(ReadAddress2)]);
`endif
      @(posedge clock);
      if (we_r) model[int'(wa)] = wd;
      #1;
      chk("rand_read_post", ReadBus, model[int'(ReadAddress)]);
    end
    WE = 1'b0;

    for (int a = 16; a < 80; a += 7) rd_chk("rand_final_sweep", a[AW-1:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
